// File: rtl/aes_decrypt_iter_pkg.sv
// rtl/aes_decrypt_iter_pkg.sv - shared types, round-count constants and inverse S-box for the AES decryptor
package aes_dec_pkg;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Byte 0x00 of the table sits in the top bits.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      MODE_128: return NR_128;
      MODE_192: return NR_192;
      MODE_256: return NR_256;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return INV_SBOX_TBL[8*idx +: 8];
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// rtl/aes_decrypt_iter_if.sv - block, key-store and plaintext handshake bundle of the AES decryptor
interface aes_decrypt_iter_if;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic [1:0]   i_mode;
  logic [3:0]   o_key_idx;
  logic [127:0] i_key;
  logic         i_iv_load;
  logic [127:0] i_iv;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;
  logic         o_err;

  modport master (
    output i_valid, i_data, i_mode, i_key, i_iv_load, i_iv, i_ready,
    input  o_ready, o_key_idx, o_valid, o_data, o_err
  );

  modport slave (
    input  i_valid, i_data, i_mode, i_key, i_iv_load, i_iv, i_ready,
    output o_ready, o_key_idx, o_valid, o_data, o_err
  );
endinterface

// File: rtl/aes_decrypt_iter_inv_round.sv
// rtl/aes_decrypt_iter_inv_round.sv - one combinational inverse AES round, optional InvMixColumns
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         bypass_mix,
  output logic [127:0] next_state
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    case (k)
      4'h9:    return x8 ^ a;
      4'hb:    return x8 ^ x2 ^ a;
      4'hd:    return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  logic [127:0] added;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  // Byte 4*c+r holds row r, column c; row r rotates right by r.
  always_comb begin
    added = '0;
    mixed = '0;
    a0    = '0;
    a1    = '0;
    a2    = '0;
    a3    = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        added[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8])
                                    ^ key[127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = added[127-32*c -: 8];
      a1 = added[119-32*c -: 8];
      a2 = added[111-32*c -: 8];
      a3 = added[103-32*c -: 8];
      mixed[127-32*c -: 32] = {
        gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
        gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
        gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
        gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
      };
    end
    next_state = bypass_mix ? added : mixed;
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128/192/256 block decryptor, one round per clock, optional CBC
module aes_decrypt_iter
  import aes_dec_pkg::*;
#(
  parameter int MAX_NR = 14,
  parameter int CBC_EN = 0
) (
  input logic               i_clk,
  input logic               i_rst,
  aes_decrypt_iter_if.slave bus
);

  localparam logic [3:0] MAX_NR_L = 4'(MAX_NR);
  localparam bit         CBC_ON   = (CBC_EN != 0);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [3:0]   nr_q, nr_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] ct_q, ct_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [127:0] round_out;
  logic [3:0]   mode_nr;
  logic         mode_ok;
  logic         ready;
  logic [3:0]   key_idx;

  aes_inv_round u_round (
    .state      (state_q),
    .key        (bus.i_key),
    .bypass_mix (fsm_q == ST_FINAL),
    .next_state (round_out)
  );

  assign mode_nr = nr_of(bus.i_mode);
  assign mode_ok = (bus.i_mode != MODE_RSVD) && (mode_nr <= MAX_NR_L);
  assign ready   = (fsm_q == ST_IDLE) && !i_rst;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    nr_d    = nr_q;
    chain_d = chain_q;
    ct_d    = ct_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    key_idx = 4'd0;
    case (fsm_q)
      ST_IDLE: begin
        key_idx = mode_nr;
        if (CBC_ON && bus.i_iv_load) chain_d = bus.i_iv;
        if (bus.i_valid && ready) begin
          if (mode_ok) begin
            state_d = bus.i_data ^ bus.i_key;
            rcnt_d  = mode_nr - 4'd1;
            nr_d    = mode_nr;
            ct_d    = bus.i_data;
            fsm_d   = ST_ROUND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ROUND: begin
        key_idx = rcnt_q;
        state_d = round_out;
        rcnt_d  = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        state_d = round_out;
        fsm_d   = ST_DONE;
      end
      ST_DONE: begin
        // o_valid comes up one cycle into DONE, giving Nr+1 cycles of latency.
        valid_d = 1'b1;
        if (valid_q && bus.i_ready) begin
          valid_d = 1'b0;
          fsm_d   = ST_IDLE;
          if (CBC_ON) chain_d = ct_q;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rcnt_q  <= '0;
      nr_q    <= '0;
      chain_q <= '0;
      ct_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      nr_q    <= nr_d;
      chain_q <= chain_d;
      ct_q    <= ct_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_key_idx = key_idx;
  assign bus.o_valid   = valid_q;
  assign bus.o_data    = state_q ^ chain_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - self-checking bench for aes_decrypt_iter against a forward-AES reference model
module tb_aes_decrypt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int           sel = 0;
  logic         valid = 1'b0, ready = 1'b0, iv_load = 1'b0;
  logic [127:0] data = '0, iv = '0;
  logic [1:0]   mode = '0;
  logic [127:0] rk [16];
  logic [7:0]   sbox [256];

  aes_decrypt_iter_if bus_e ();
  aes_decrypt_iter_if bus_c ();
  aes_decrypt_iter_if bus_n ();

  aes_decrypt_iter #(.MAX_NR(14), .CBC_EN(0)) u_ecb (.i_clk(clk), .i_rst(rst), .bus(bus_e.slave));
  aes_decrypt_iter #(.MAX_NR(14), .CBC_EN(1)) u_cbc (.i_clk(clk), .i_rst(rst), .bus(bus_c.slave));
  aes_decrypt_iter #(.MAX_NR(10), .CBC_EN(0)) u_n10 (.i_clk(clk), .i_rst(rst), .bus(bus_n.slave));

  assign bus_e.i_valid = valid && (sel == 0);
  assign bus_c.i_valid = valid && (sel == 1);
  assign bus_n.i_valid = valid && (sel == 2);
  assign bus_e.i_ready = ready && (sel == 0);
  assign bus_c.i_ready = ready && (sel == 1);
  assign bus_n.i_ready = ready && (sel == 2);
  assign bus_e.i_iv_load = iv_load && (sel == 0);
  assign bus_c.i_iv_load = iv_load && (sel == 1);
  assign bus_n.i_iv_load = iv_load && (sel == 2);
  assign bus_e.i_data = data;
  assign bus_c.i_data = data;
  assign bus_n.i_data = data;
  assign bus_e.i_mode = mode;
  assign bus_c.i_mode = mode;
  assign bus_n.i_mode = mode;
  assign bus_e.i_iv = iv;
  assign bus_c.i_iv = iv;
  assign bus_n.i_iv = iv;
  assign bus_e.i_key = rk[bus_e.o_key_idx];
  assign bus_c.i_key = rk[bus_c.o_key_idx];
  assign bus_n.i_key = rk[bus_n.o_key_idx];

  logic         m_ready, m_valid, m_err;
  logic [127:0] m_data;
  logic [3:0]   m_kidx;

  always_comb begin
    m_ready = bus_e.o_ready;
    m_valid = bus_e.o_valid;
    m_err   = bus_e.o_err;
    m_data  = bus_e.o_data;
    m_kidx  = bus_e.o_key_idx;
    if (sel == 1) begin
      m_ready = bus_c.o_ready;
      m_valid = bus_c.o_valid;
      m_err   = bus_c.o_err;
      m_data  = bus_c.o_data;
      m_kidx  = bus_c.o_key_idx;
    end else if (sel == 2) begin
      m_ready = bus_n.o_ready;
      m_valid = bus_n.o_valid;
      m_err   = bus_n.o_err;
      m_data  = bus_n.o_data;
      m_kidx  = bus_n.o_key_idx;
    end
  end

  // Reference model: GF(2^8) arithmetic, S-box derived from field inverses, forward AES.
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p, a;
    p = '0;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int m);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2*m;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one block, waits (bounded) for o_valid, then completes the output handshake.
  // lat = edges from accept to o_valid, or -1 when o_valid never arrives.
  task automatic decrypt(input logic [127:0] ct, input logic [1:0] md, input logic ld,
                         input logic [127:0] ivv, output logic [127:0] out, output int lat);
    int n;
    data = ct; mode = md; valid = 1'b1; iv_load = ld; iv = ivv;
    @(posedge clk); #1;
    valid = 1'b0; iv_load = 1'b0; data = rnd128(); mode = 2'($urandom);
    n = 0;
    while (!m_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = m_valid ? n : -1;
    out = m_data;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", m_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", m_err); end
    checks++; if (m_data !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", m_data); end
    rst = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", m_ready); end
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      #1;
      checks++;
      if (m_kidx !== 4'(10 + 2*m)) begin
        errors++; $display("FAIL idle_key_idx mode=%0d got=%0d exp=%0d", m, m_kidx, 10 + 2*m);
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_vectors();
    logic [255:0] keys [3];
    logic [127:0] cts [3];
    logic [127:0] out;
    int lat;
    keys[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    keys[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    keys[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    cts[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    cts[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    cts[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
    sel = 0;
    for (int m = 0; m < 3; m++) begin
      expand(keys[m], m);
      decrypt(cts[m], 2'(m), 1'b0, '0, out, lat);
      checks++;
      if (out !== 128'h00112233445566778899aabbccddeeff) begin
        errors++; $display("FAIL vector_data mode=%0d got=%h exp=00112233445566778899aabbccddeeff", m, out);
      end
      checks++;
      if (lat != 11 + 2*m) begin errors++; $display("FAIL vector_latency mode=%0d got=%0d exp=%0d", m, lat, 11 + 2*m); end
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, out;
    int m, lat;
    sel = 0;
    for (int k = 0; k < 9; k++) begin
      m = $urandom_range(0, 2);
      expand({rnd128(), rnd128()}, m);
      pt = rnd128();
      decrypt(enc(pt, 10 + 2*m), 2'(m), 1'b0, '0, out, lat);
      checks++;
      if (out !== pt) begin errors++; $display("FAIL random_data k=%0d mode=%0d got=%h exp=%h", k, m, out, pt); end
      checks++;
      if (lat != 11 + 2*m) begin errors++; $display("FAIL random_latency k=%0d got=%0d exp=%0d", k, lat, 11 + 2*m); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt, ct;
    int n;
    sel = 0;
    expand({rnd128(), 128'h0}, 0);
    pt = rnd128();
    ct = enc(pt, 10);
    data = ct; mode = 2'd0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n != 11) begin errors++; $display("FAIL hold_latency got=%0d exp=11", n); end
    checks++; if (m_kidx !== 4'd0) begin errors++; $display("FAIL done_key_idx got=%0d exp=0", m_kidx); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== pt) begin
        errors++; $display("FAIL hold_stable cycle=%0d valid=%b data=%h exp_data=%h", c, m_valid, m_data, pt);
      end
      @(posedge clk); #1;
    end
    data = ct; mode = 2'd0; valid = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_ready !== 1'b1) begin
      errors++; $display("FAIL idle_after_handshake valid=%b ready=%b exp valid=0 ready=1", m_valid, m_ready);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL accept_after_idle ready=%b exp=0", m_ready); end
    n = 0;
    while (!m_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 11 || m_data !== pt) begin
      errors++; $display("FAIL second_block lat=%0d data=%h exp lat=11 data=%h", n, m_data, pt);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reject();
    logic [127:0] pt, out;
    int lat;
    bit seen;
    for (int p = 0; p < 2; p++) begin
      sel = (p == 0) ? 0 : 2;
      data = rnd128(); mode = (p == 0) ? 2'd3 : 2'd2; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL reject_err_pulse sel=%0d got=%b exp=1", sel, m_err); end
      @(posedge clk); #1;
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reject_err_single sel=%0d got=%b exp=0", sel, m_err); end
      seen = 1'b0;
      repeat (16) begin
        @(posedge clk); #1;
        if (m_valid || !m_ready) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reject_stays_idle sel=%0d got=%b exp=0", sel, seen); end
    end
    sel = 2;
    expand({rnd128(), 128'h0}, 0);
    pt = rnd128();
    decrypt(enc(pt, 10), 2'd0, 1'b0, '0, out, lat);
    checks++;
    if (out !== pt || lat != 11) begin
      errors++; $display("FAIL max_nr_boundary data=%h lat=%0d exp data=%h lat=11", out, lat, pt);
    end
    sel = 0;
  endtask

  task automatic test_cbc();
    logic [127:0] p1, p2, p3, c1, c2, c3, iv1, iv2, out;
    int lat;
    expand({rnd128(), rnd128()}, 1);
    p1 = rnd128(); p2 = rnd128(); p3 = rnd128();
    c1 = enc(p1, 12); c2 = enc(p2, 12); c3 = enc(p3, 12);
    iv1 = rnd128(); iv2 = rnd128();
    sel = 1;
    decrypt(c1, 2'd1, 1'b1, iv1, out, lat);
    checks++; if (out !== (p1 ^ iv1)) begin errors++; $display("FAIL cbc_first got=%h exp=%h", out, p1 ^ iv1); end
    decrypt(c2, 2'd1, 1'b0, rnd128(), out, lat);
    checks++; if (out !== (p2 ^ c1)) begin errors++; $display("FAIL cbc_chain got=%h exp=%h", out, p2 ^ c1); end
    iv = iv2; iv_load = 1'b1;
    @(posedge clk); #1;
    iv_load = 1'b0; iv = rnd128();
    decrypt(c3, 2'd1, 1'b0, rnd128(), out, lat);
    checks++; if (out !== (p3 ^ iv2)) begin errors++; $display("FAIL cbc_idle_iv got=%h exp=%h", out, p3 ^ iv2); end
    sel = 0;
    decrypt(c1, 2'd1, 1'b1, iv1, out, lat);
    checks++; if (out !== p1) begin errors++; $display("FAIL ecb_ignores_iv got=%h exp=%h", out, p1); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt, out;
    int lat;
    bit seen;
    sel = 0;
    expand({rnd128(), rnd128()}, 2);
    pt = rnd128();
    data = enc(pt, 14); mode = 2'd2; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset valid=%b ready=%b exp 0 0", m_valid, m_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_release ready=%b exp=1", m_ready); end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_output got=%b exp=0", seen); end
    decrypt(enc(pt, 14), 2'd2, 1'b0, '0, out, lat);
    checks++;
    if (out !== pt || lat != 15) begin
      errors++; $display("FAIL after_reset_block data=%h lat=%0d exp data=%h lat=15", out, lat, pt);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rk[i] = '0;
    build_sbox();
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reject();
    test_cbc();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
